dcache_sram_nway: RTL and testbench

Parametrised N-way set-associative tag/data array for the L1 data cache, successor to the fixed 16-set 2-way array. Stores valid/dirty/tag/line per way, keeps true-LRU age per set, and answers one request per cycle with a registered response: hit way and data, or on a miss the victim way, tag, dirty bit and line for write-back. Sits between the dcache controller FSM and nothing below it; the controller owns memory traffic.

---
 rtl/dcache_sram_nway_pkg.sv | 29 ++
 rtl/dcache_sram_nway_if.sv | 40 ++++
 rtl/dcache_sram_nway_lru_age.sv | 48 ++++
 rtl/dcache_sram_nway.sv | 137 +++++++++++++
 tb/tb_dcache_sram_nway.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/dcache_sram_nway_pkg.sv
// dcache_pkg: shared definitions for the N-way dcache tag/data array.
//   op_e         request operation encodings
//   rsp_flags_t  registered single-bit response flags
//   log2c        ceiling log2, used to size index and way fields
package dcache_pkg;

  typedef enum logic [1:0] {
    LOOKUP    = 2'b00,
    WRITE_HIT = 2'b01,
    FILL      = 2'b10,
    INVAL     = 2'b11
  } op_e;

  typedef struct packed {
    logic rsp_valid;
    logic hit;
    logic dirty;
  } rsp_flags_t;

  function automatic int unsigned log2c(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway_if: request/response bundle between the dcache
// controller (master) and the tag/data array (slave).
//   req_i/op_i/idx_i/tag_i/data_i           request, driven by the controller
//   rsp_valid_o/hit_o/way_o/tag_o/
//   dirty_o/data_o                           registered response from the array
import dcache_pkg::*;

interface dcache_sram_nway_if #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
);
  localparam int IDX_W = log2c(SETS);
  localparam int WAY_W = log2c(WAYS);

  logic              req_i;
  op_e               op_i;
  logic [IDX_W-1:0]  idx_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;

  logic              rsp_valid_o;
  logic              hit_o;
  logic [WAY_W-1:0]  way_o;
  logic [TAG_W-1:0]  tag_o;
  logic              dirty_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output req_i, op_i, idx_i, tag_i, data_i,
    input  rsp_valid_o, hit_o, way_o, tag_o, dirty_o, data_o
  );

  modport slave (
    input  req_i, op_i, idx_i, tag_i, data_i,
    output rsp_valid_o, hit_o, way_o, tag_o, dirty_o, data_o
  );

endinterface

// File: rtl/dcache_sram_nway_lru_age.sv
// dcache_lru_age: combinational true-LRU helper for one set.
//   age_i          current ages of the set (permutation of 0..WAYS-1)
//   valid_i        valid bits of the set
//   promote_way_i  way to make most-recently-used
//   age_o          ages after promoting promote_way_i
//   victim_o       lowest invalid way, else the oldest way
import dcache_pkg::*;

module dcache_lru_age #(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0][WAY_W-1:0] age_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAY_W-1:0]           promote_way_i,
  output logic [WAYS-1:0][WAY_W-1:0] age_o,
  output logic [WAY_W-1:0]           victim_o
);

  // Victim logic is kept in its own process: the top feeds victim_o back
  // into promote_way_i, so it must not depend on the promotion input.
  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_i[w] == WAY_W'(WAYS - 1)) victim_o = WAY_W'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = WAY_W'(w);
    end
  end

  // Ways younger than the promoted one age by one; older ways hold,
  // which keeps the ages a permutation.
  always_comb begin
    logic [WAY_W-1:0] old_age;
    old_age = age_i[promote_way_i];
    age_o   = age_i;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == promote_way_i) begin
        age_o[w] = '0;
      end else if (age_i[w] < old_age) begin
        age_o[w] = age_i[w] + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: parametrised N-way set-associative tag/data array with
// true-LRU replacement and a one-cycle registered response.
//   clk_i  clock
//   rst_i  synchronous active-high reset (clears valid/dirty, resets ages)
//   bus    dcache_sram_nway_if slave: request in, hit/victim report out
import dcache_pkg::*;

module dcache_sram_nway #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_sram_nway_if.slave     bus
);

  localparam int IDX_W = log2c(SETS);
  localparam int WAY_W = log2c(WAYS);

  logic [WAYS-1:0]            valid_mem [SETS];
  logic [WAYS-1:0]            dirty_mem [SETS];
  logic [WAYS-1:0][WAY_W-1:0] age_mem   [SETS];
  logic [TAG_W-1:0]           tag_mem   [SETS][WAYS];
  logic [LINE_W-1:0]          data_mem  [SETS][WAYS];

  rsp_flags_t        rsp_q;
  logic [WAY_W-1:0]  way_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0] data_q;

  logic [IDX_W-1:0]           idx;
  logic                       hit;
  logic [WAY_W-1:0]           hit_way;
  logic [WAY_W-1:0]           victim;
  logic [WAY_W-1:0]           sel_way;
  logic [WAYS-1:0][WAY_W-1:0] next_age;
  logic                       do_promote;

  assign idx = bus.idx_i;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[idx][w] && (tag_mem[idx][w] == bus.tag_i)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // The reported way is also the FILL target, so a refill of a resident
  // tag reuses its way instead of creating a duplicate.
  assign sel_way = hit ? hit_way : victim;

  dcache_lru_age #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_lru (
    .age_i         (age_mem[idx]),
    .valid_i       (valid_mem[idx]),
    .promote_way_i (sel_way),
    .age_o         (next_age),
    .victim_o      (victim)
  );

  // INVAL leaves ages alone; FILL always promotes its target.
  always_comb begin
    do_promote = 1'b0;
    unique case (bus.op_i)
      LOOKUP, WRITE_HIT: do_promote = hit;
      FILL:              do_promote = 1'b1;
      INVAL:             do_promote = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_mem[s][w] <= WAY_W'(w);
        end
      end
      rsp_q  <= '0;
      way_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      rsp_q.rsp_valid <= bus.req_i;
      if (bus.req_i) begin
        rsp_q.hit   <= hit;
        rsp_q.dirty <= dirty_mem[idx][sel_way];
        way_q       <= sel_way;
        tag_q       <= tag_mem[idx][sel_way];
        data_q      <= data_mem[idx][sel_way];
        unique case (bus.op_i)
          LOOKUP: ;
          WRITE_HIT: if (hit) dirty_mem[idx][hit_way] <= 1'b1;
          FILL: begin
            valid_mem[idx][sel_way] <= 1'b1;
            dirty_mem[idx][sel_way] <= 1'b0;
          end
          INVAL: if (hit) begin
            valid_mem[idx][hit_way] <= 1'b0;
            dirty_mem[idx][hit_way] <= 1'b0;
          end
        endcase
        if (do_promote) age_mem[idx] <= next_age;
      end
    end
  end

  // Tag/data storage is never cleared, but a request coinciding with
  // reset must not write it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && bus.req_i) begin
      if (bus.op_i == FILL) begin
        tag_mem[idx][sel_way]  <= bus.tag_i;
        data_mem[idx][sel_way] <= bus.data_i;
      end else if (bus.op_i == WRITE_HIT && hit) begin
        data_mem[idx][hit_way] <= bus.data_i;
      end
    end
  end

  assign bus.rsp_valid_o = rsp_q.rsp_valid;
  assign bus.hit_o       = rsp_q.hit;
  assign bus.dirty_o     = rsp_q.dirty;
  assign bus.way_o       = way_q;
  assign bus.tag_o       = tag_q;
  assign bus.data_o      = data_q;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed self-checking bench. Instance A is 2-way,
// instance B is 4-way; both 16 sets, 23-bit tags, 256-bit lines.
import dcache_pkg::*;

module tb_dcache_sram_nway;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dcache_sram_nway_if #(.SETS(16), .WAYS(2), .TAG_W(23), .LINE_W(256)) a_if ();
  dcache_sram_nway_if #(.SETS(16), .WAYS(4), .TAG_W(23), .LINE_W(256)) b_if ();

  dcache_sram_nway #(.SETS(16), .WAYS(2), .TAG_W(23), .LINE_W(256)) u_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (a_if.slave)
  );

  dcache_sram_nway #(.SETS(16), .WAYS(4), .TAG_W(23), .LINE_W(256)) u_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] k);
    return {8{k}};
  endfunction

  // Drive one request at the falling edge, let it be captured at the next
  // rising edge, then drop req so the response can be sampled.
  task automatic applyStimulus(input int sel, input op_e op, input logic [3:0] idx,
                               input logic [22:0] tag, input logic [255:0] data);
    @(negedge clk);
    if (sel == 0) begin
      a_if.req_i = 1'b1; a_if.op_i = op; a_if.idx_i = idx;
      a_if.tag_i = tag;  a_if.data_i = data;
    end else begin
      b_if.req_i = 1'b1; b_if.op_i = op; b_if.idx_i = idx;
      b_if.tag_i = tag;  b_if.data_i = data;
    end
    @(posedge clk);
    #1;
    a_if.req_i = 1'b0;
    b_if.req_i = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a_if.req_i = 1'b0; a_if.op_i = LOOKUP; a_if.idx_i = '0; a_if.tag_i = '0; a_if.data_i = '0;
    b_if.req_i = 1'b0; b_if.op_i = LOOKUP; b_if.idx_i = '0; b_if.tag_i = '0; b_if.data_i = '0;

    idleCycle();
    idleCycle();
    checkOutput("reset_rsp_valid", 256'(a_if.rsp_valid_o), 256'd0);
    checkOutput("reset_hit",       256'(a_if.hit_o),       256'd0);
    checkOutput("reset_data",      a_if.data_o,            256'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] first lookup after reset misses on way 0");
    applyStimulus(0, LOOKUP, 4'd3, 23'h1A, '0);
    checkOutput("lk0_rsp_valid", 256'(a_if.rsp_valid_o), 256'd1);
    checkOutput("lk0_hit",       256'(a_if.hit_o),       256'd0);
    checkOutput("lk0_way",       256'(a_if.way_o),       256'd0);
    checkOutput("lk0_dirty",     256'(a_if.dirty_o),     256'd0);

    $display("[TB] 4-way set fills and LRU eviction");
    applyStimulus(1, FILL, 4'd5, 23'hA, line_of(32'hAAAA0001));
    checkOutput("b_fillA_way", 256'(b_if.way_o), 256'd0);
    applyStimulus(1, FILL, 4'd5, 23'hB, line_of(32'hBBBB0002));
    checkOutput("b_fillB_way", 256'(b_if.way_o), 256'd1);
    applyStimulus(1, FILL, 4'd5, 23'hC, line_of(32'hCCCC0003));
    checkOutput("b_fillC_way", 256'(b_if.way_o), 256'd2);
    applyStimulus(1, FILL, 4'd5, 23'hD, line_of(32'hDDDD0004));
    checkOutput("b_fillD_way", 256'(b_if.way_o), 256'd3);
    // ages now way0..3 = 3,2,1,0 so way 0 (tag A) is evicted
    applyStimulus(1, FILL, 4'd5, 23'hE, line_of(32'hEEEE0005));
    checkOutput("b_fillE_hit",  256'(b_if.hit_o), 256'd0);
    checkOutput("b_fillE_way",  256'(b_if.way_o), 256'd0);
    checkOutput("b_fillE_tag",  256'(b_if.tag_o), 256'hA);
    checkOutput("b_fillE_data", b_if.data_o,      line_of(32'hAAAA0001));
    // ages 0,3,2,1: miss reports way 1 (tag B) as victim
    applyStimulus(1, LOOKUP, 4'd5, 23'hA, '0);
    checkOutput("b_lkA_hit", 256'(b_if.hit_o), 256'd0);
    checkOutput("b_lkA_way", 256'(b_if.way_o), 256'd1);
    applyStimulus(1, LOOKUP, 4'd5, 23'hB, '0);
    checkOutput("b_lkB_hit",  256'(b_if.hit_o), 256'd1);
    checkOutput("b_lkB_way",  256'(b_if.way_o), 256'd1);
    checkOutput("b_lkB_data", b_if.data_o,      line_of(32'hBBBB0002));

    $display("[TB] dirty victim write-back in 2-way set");
    applyStimulus(0, FILL, 4'd2, 23'hA, line_of(32'h12345678));
    checkOutput("a_fillA_way", 256'(a_if.way_o), 256'd0);
    applyStimulus(0, WRITE_HIT, 4'd2, 23'hA, {256{1'b1}});
    checkOutput("a_wh_hit",   256'(a_if.hit_o),   256'd1);
    checkOutput("a_wh_dirty", 256'(a_if.dirty_o), 256'd0);
    checkOutput("a_wh_data",  a_if.data_o,        line_of(32'h12345678));
    applyStimulus(0, FILL, 4'd2, 23'hC, line_of(32'h0000C0C0));
    checkOutput("a_fillC_way", 256'(a_if.way_o), 256'd1);
    applyStimulus(0, FILL, 4'd2, 23'hB, line_of(32'h0000B0B0));
    checkOutput("a_fillB_hit",   256'(a_if.hit_o),   256'd0);
    checkOutput("a_fillB_way",   256'(a_if.way_o),   256'd0);
    checkOutput("a_fillB_tag",   256'(a_if.tag_o),   256'hA);
    checkOutput("a_fillB_dirty", 256'(a_if.dirty_o), 256'd1);
    checkOutput("a_fillB_data",  a_if.data_o,        {256{1'b1}});
    applyStimulus(0, WRITE_HIT, 4'd2, 23'hA, line_of(32'hDEADBEEF));
    checkOutput("a_whmiss_hit", 256'(a_if.hit_o), 256'd0);

    $display("[TB] back-to-back fill then lookup");
    applyStimulus(0, FILL, 4'd7, 23'h9, line_of(32'h99990009));
    applyStimulus(0, LOOKUP, 4'd7, 23'h9, '0);
    checkOutput("a_b2b_hit",  256'(a_if.hit_o), 256'd1);
    checkOutput("a_b2b_way",  256'(a_if.way_o), 256'd0);
    checkOutput("a_b2b_data", a_if.data_o,      line_of(32'h99990009));
    idleCycle();
    checkOutput("a_idle_rsp_valid", 256'(a_if.rsp_valid_o), 256'd0);
    checkOutput("a_idle_data_hold", a_if.data_o,            line_of(32'h99990009));

    $display("[TB] invalidate then refill, duplicate fill");
    // set 5 ways: E,B,C,D ages 1,0,3,2; invalidate MRU way 1
    applyStimulus(1, INVAL, 4'd5, 23'hB, '0);
    checkOutput("b_inval_hit",  256'(b_if.hit_o), 256'd1);
    checkOutput("b_inval_way",  256'(b_if.way_o), 256'd1);
    checkOutput("b_inval_data", b_if.data_o,      line_of(32'hBBBB0002));
    applyStimulus(1, FILL, 4'd5, 23'hF, line_of(32'hFFFF0006));
    checkOutput("b_fillF_hit", 256'(b_if.hit_o), 256'd0);
    checkOutput("b_fillF_way", 256'(b_if.way_o), 256'd1);
    applyStimulus(1, FILL, 4'd5, 23'hD, line_of(32'hD2D20007));
    checkOutput("b_dupD_hit",  256'(b_if.hit_o), 256'd1);
    checkOutput("b_dupD_way",  256'(b_if.way_o), 256'd3);
    checkOutput("b_dupD_data", b_if.data_o,      line_of(32'hDDDD0004));
    applyStimulus(1, LOOKUP, 4'd5, 23'hD, '0);
    checkOutput("b_lkD_way",  256'(b_if.way_o), 256'd3);
    checkOutput("b_lkD_data", b_if.data_o,      line_of(32'hD2D20007));
    // ages now 2,1,3,0: miss victim is way 2 (tag C)
    applyStimulus(1, LOOKUP, 4'd5, 23'h77, '0);
    checkOutput("b_lkmiss_way", 256'(b_if.way_o), 256'd2);
    checkOutput("b_lkmiss_tag", 256'(b_if.tag_o), 256'hC);

    $display("[TB] reset concurrent with fill");
    @(negedge clk);
    rst = 1'b1;
    a_if.req_i = 1'b1; a_if.op_i = FILL; a_if.idx_i = 4'd9;
    a_if.tag_i = 23'h55; a_if.data_i = line_of(32'h55555555);
    @(posedge clk);
    #1;
    a_if.req_i = 1'b0;
    checkOutput("a_rst_rsp_valid", 256'(a_if.rsp_valid_o), 256'd0);
    checkOutput("a_rst_data",      a_if.data_o,            256'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, LOOKUP, 4'd9, 23'h55, '0);
    checkOutput("a_postrst_hit9",   256'(a_if.hit_o),       256'd0);
    checkOutput("a_postrst_valid9", 256'(a_if.rsp_valid_o), 256'd1);
    applyStimulus(0, LOOKUP, 4'd7, 23'h9, '0);
    checkOutput("a_postrst_hit7", 256'(a_if.hit_o), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
